way_select_pipe: RTL
====================

WAY_SELECT_PIPE -- requirements
Module: way_select_pipe

Interface
REQ-001 The block SHALL have parameter SEL_WIDTH, default 3, select width; channel count N = 2**SEL_WIDTH.
REQ-002 The block SHALL have parameter W, default 8, bits per channel.
REQ-003 The block SHALL have parameter ONEHOT, default 0; 0 = binary select, 1 = one-hot hit-vector select.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, input beat present.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 The block SHALL have port in_data, input, N*W, channel k on bits [k*W +: W].
REQ-009 The block SHALL have port in_sel, input, SEL_WIDTH when ONEHOT=0 and N when ONEHOT=1, channel select or hit vector.
REQ-010 The block SHALL have port out_valid, output, 1, output beat present.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts the beat.
REQ-012 The block SHALL have port out_data, output, W, selected channel.
REQ-013 The block SHALL have port out_idx, output, SEL_WIDTH, binary index of the selected channel.
REQ-014 The block SHALL have port out_err, output, 1, select-error flag for the beat.

Function
REQ-015 An input transfer SHALL occur on a clock edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-016 At input transfer, ONEHOT=0 SHALL capture out_data = channel in_sel, out_idx = in_sel, out_err = 0.
REQ-017 With ONEHOT=1 and exactly one bit k set, the block SHALL capture channel k, out_idx = k and out_err = 0.
REQ-018 With ONEHOT=1 and more than one bit set, the block SHALL capture the lowest set index with out_err = 1.
REQ-019 With ONEHOT=1 and zero bits set, the block SHALL capture out_data = 0, out_idx = 0 and out_err = 1.
REQ-020 Storage SHALL be a main output register plus one skid register; out_* SHALL be driven only from the main register, which is registered with no combinational in-to-out path.
REQ-021 Latency SHALL be one cycle: a beat accepted at edge t is visible on out_* after edge t when the main register was empty or draining at t.
REQ-022 in_ready SHALL be registered and equal to !skid_valid, with no combinational dependence on out_ready.
REQ-023 Accepted beat routing at an edge:
- main empty or draining: the beat SHALL load main.
- main full and not draining: the beat SHALL load skid.
REQ-024 When skid is valid and main drains, skid SHALL move to main; no input transfer is possible that cycle because in_ready = 0.
REQ-025 Beats SHALL leave in acceptance order, with none dropped or duplicated.
REQ-026 With in_valid and out_ready held high, throughput SHALL be one beat per cycle.
REQ-027 While out_valid = 1 and out_ready = 0, out_data, out_idx and out_err SHALL hold stable.
REQ-028 Data fields SHALL be sampled only at transfer; changes to in_data or in_sel with in_valid = 0 SHALL have no effect.

Reset
REQ-029 While rst_n = 0, outputs SHALL be: out_valid = 0, out_data = 0, out_idx = 0, out_err = 0, skid_valid = 0, in_ready = 1.
REQ-030 in_valid SHALL be ignored while rst_n = 0.
REQ-031 Reset asserted mid-operation SHALL discard both main and skid contents immediately, with no output transfer in that cycle.

Structure
REQ-032 Default SEL_WIDTH and W values SHALL reside in the shared cache_pkg package so that cache datapath users agree.
REQ-033 Channel selection SHALL instantiate the existing muxNto1 sub-module (SEL_WIDTH, W) on the resolved binary index.
REQ-034 One-hot to binary priority encoding and error detection SHALL be local logic inside this block.

Verification
REQ-035 Bench setup: SEL_WIDTH=3, W=8, channel k = k*16+8'h05.
REQ-036 Scenario, ONEHOT=0 sweep: in_sel = 0..7 back-to-back, out_ready = 1 -> out_data = 05,15,..,75, one per cycle, latency 1, out_err = 0.
REQ-037 Scenario, backpressure: out_ready = 0 for 3 cycles while in_sel = 2,3,4 are offered -> beats 2 and 3 accepted, in_ready falls after the second; after release, out_data = 25 then 35 then 45 in order.
REQ-038 Scenario, ONEHOT=1 hits: in_sel = 8'b0010_0000 -> out_data = 55, idx 5, err 0; 8'b1001_0000 -> out_data = 45, idx 4, err 1; 8'h00 -> out_data = 00, idx 0, err 1.
REQ-039 Scenario, stall stability: out_valid = 1, out_ready = 0 for 5 cycles while in_data changes -> out_* unchanged each cycle.
REQ-040 Scenario, mid-stream reset: with main and skid both full, assert rst_n = 0 asynchronously -> out_valid = 0 and in_ready = 1 before the next clock edge; the first post-reset beat is the first new beat output.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache datapath defaults so every way-select user agrees on geometry.
package cache_pkg;
  localparam int CACHE_SEL_WIDTH = 3;
  localparam int CACHE_W         = 8;
endpackage

// File: rtl/muxNto1.sv
// Plain N:1 channel multiplexer on a binary select.
module muxNto1 #(
  parameter int SEL_WIDTH = 3,
  parameter int W         = 8,
  localparam int N        = 2**SEL_WIDTH
) (
  input  logic [N*W-1:0]       data_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic [W-1:0]         data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == k[SEL_WIDTH-1:0]) data_o = data_i[k*W +: W];
    end
  end

endmodule

// File: rtl/way_select_pipe.sv
// Way select with one-cycle registered output and a single skid entry;
// optional one-hot hit-vector select with priority resolution and error flag.
module way_select_pipe
  import cache_pkg::*;
#(
  parameter int SEL_WIDTH = CACHE_SEL_WIDTH,
  parameter int W         = CACHE_W,
  parameter bit ONEHOT    = 1'b0,
  localparam int N        = 2**SEL_WIDTH,
  localparam int SELW     = ONEHOT ? N : SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [SEL_WIDTH-1:0] out_idx,
  output logic                 out_err
);

  logic [SEL_WIDTH-1:0] idx_res;
  logic                 err_res;
  logic                 none_res;
  logic [W-1:0]         mux_data;
  logic [W-1:0]         new_data;

  // Lowest set bit wins; zero or multiple hits flag an error.
  if (ONEHOT) begin : g_onehot
    always_comb begin
      idx_res  = '0;
      none_res = 1'b1;
      for (int k = N-1; k >= 0; k--) begin
        if (in_sel[k]) begin
          idx_res  = k[SEL_WIDTH-1:0];
          none_res = 1'b0;
        end
      end
      err_res = none_res || ((in_sel & (in_sel - SELW'(1))) != '0);
    end
  end else begin : g_binary
    assign idx_res  = in_sel;
    assign none_res = 1'b0;
    assign err_res  = 1'b0;
  end

  muxNto1 #(.SEL_WIDTH(SEL_WIDTH), .W(W)) u_mux (
    .data_i (in_data),
    .sel_i  (idx_res),
    .data_o (mux_data)
  );

  assign new_data = none_res ? '0 : mux_data;

  logic                 main_vld_q, main_vld_d;
  logic [W-1:0]         main_data_q, main_data_d;
  logic [SEL_WIDTH-1:0] main_idx_q, main_idx_d;
  logic                 main_err_q, main_err_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [W-1:0]         skid_data_q, skid_data_d;
  logic [SEL_WIDTH-1:0] skid_idx_q, skid_idx_d;
  logic                 skid_err_q, skid_err_d;
  logic                 in_fire, main_open;

  assign in_ready  = !skid_vld_q;
  assign in_fire   = in_valid && in_ready;
  // Main can take a beat this edge if it is empty or its beat is leaving.
  assign main_open = !main_vld_q || out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_idx_d  = main_idx_q;
    main_err_d  = main_err_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    skid_err_d  = skid_err_q;
    if (main_open) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_idx_d  = skid_idx_q;
        main_err_d  = skid_err_q;
        skid_vld_d  = 1'b0;
      end else if (in_fire) begin
        main_vld_d  = 1'b1;
        main_data_d = new_data;
        main_idx_d  = idx_res;
        main_err_d  = err_res;
      end else begin
        main_vld_d  = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_data_d = new_data;
      skid_idx_d  = idx_res;
      skid_err_d  = err_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_idx_q  <= '0;
      main_err_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_idx_q  <= main_idx_d;
      main_err_q  <= main_err_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_idx   = main_idx_q;
  assign out_err   = main_err_q;

endmodule
